// File: rtl/and_gate_pkg.sv
// ---------------------------------------------------------------------------
// and_gate_pkg
// Shared defaults and helpers for the and_gate primitive and its lane
// sub-module.
//   DEFAULT_WIDTH  default number of independent AND lanes
//   DEFAULT_CNT_W  default width of the high-cycle activity counter
//   cnt_sat_max()  all-ones value of a counter of the given width, which is
//                  the value the activity counter saturates at
// ---------------------------------------------------------------------------
package and_gate_pkg;

   localparam int unsigned DEFAULT_WIDTH = 1;
   localparam int unsigned DEFAULT_CNT_W = 16;

   // The result is computed in 64 bits and narrowed by the caller. For a
   // 64-bit request the shift yields zero and the subtraction wraps to
   // all-ones, which is still the correct saturation value.
   function automatic logic [63:0] cnt_sat_max(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/and_gate_lane.sv
// ---------------------------------------------------------------------------
// and_gate_lane
// One lane of the and_gate primitive: the combinational AND, a registered
// copy of it, and a one-cycle rising-edge pulse on that registered copy.
// Ports:
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   a_i       in   operand A bit
//   b_i       in   operand B bit
//   c_o       out  combinational a_i & b_i (unaffected by clk and rst)
//   c_q_o     out  c_o registered one cycle, 0 in reset
//   c_rise_o  out  high for one cycle when c_q_o went 0->1 on the last edge
// ---------------------------------------------------------------------------
module and_gate_lane
   import and_gate_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic a_i,
   input  logic b_i,
   output logic c_o,
   output logic c_q_o,
   output logic c_rise_o
);

   logic out_q;
   logic out_d;
   logic rise_q;
   logic rise_d;

   assign c_o = a_i & b_i;

   // The rise pulse compares the incoming value against the currently held
   // copy, so it asserts on the same edge that the registered copy first
   // captures a 1 and clears on the next edge while the input stays high.
   always_comb begin
      out_d  = c_o;
      rise_d = c_o & ~out_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q  <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         out_q  <= out_d;
         rise_q <= rise_d;
      end
   end

   assign c_q_o    = out_q;
   assign c_rise_o = rise_q;

endmodule

// File: rtl/and_gate.sv
// ---------------------------------------------------------------------------
// and_gate
// Bitwise 2-input AND stage. Besides the combinational result it provides a
// registered copy, a per-lane rising-edge pulse and a saturating count of the
// cycles in which lane 0 was high, so clocked logic and debug can observe the
// gate directly.
// Parameters:
//   WIDTH    number of independent AND lanes (>= 1)
//   CNT_W    width of the high-cycle counter (>= 2)
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   a        in   operand A
//   b        in   operand B
//   c        out  combinational a & b
//   c_q      out  c registered one cycle
//   c_rise   out  per-lane pulse: c_q went 0->1 on the last edge
//   cnt_clr  in   synchronous clear of hit_cnt
//   hit_cnt  out  number of cycles with c[0] high, saturating at all-ones
// ---------------------------------------------------------------------------
module and_gate
   import and_gate_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] c,
   output logic [WIDTH-1:0] c_q,
   output logic [WIDTH-1:0] c_rise,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] CntMax = CNT_W'(cnt_sat_max(CNT_W));

   logic [CNT_W-1:0] hitCnt_q;
   logic [CNT_W-1:0] hitCnt_d;

   // Each lane is self-contained; lanes share only clock and reset.
   for (genvar i = 0; i < WIDTH; i++) begin : gLane
      and_gate_lane uLane (
         .clk      (clk),
         .rst      (rst),
         .a_i      (a[i]),
         .b_i      (b[i]),
         .c_o      (c[i]),
         .c_q_o    (c_q[i]),
         .c_rise_o (c_rise[i])
      );
   end

   // Activity counter next state. Clear outranks counting, so a clear in a
   // cycle where lane 0 is high still leaves zero. At all-ones the counter
   // holds instead of wrapping, so a saturated value is never mistaken for a
   // small count.
   always_comb begin
      hitCnt_d = hitCnt_q;
      if (cnt_clr) begin
         hitCnt_d = '0;
      end else if (c[0] && (hitCnt_q != CntMax)) begin
         hitCnt_d = hitCnt_q + CNT_W'(1);
      end
   end

   // Reset outranks both clear and increment.
   always_ff @(posedge clk) begin
      if (rst) begin
         hitCnt_q <= '0;
      end else begin
         hitCnt_q <= hitCnt_d;
      end
   end

   assign hit_cnt = hitCnt_q;

endmodule

// File: tb/tb_and_gate.sv
// ---------------------------------------------------------------------------
// tb_and_gate
// Directed self-checking bench for and_gate. Two instances share one clock:
// a narrow one (WIDTH=1, CNT_W=16) and a wide one (WIDTH=4, CNT_W=2) for
// multi-lane behaviour and counter saturation. Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_and_gate;

   logic        clk;
   int          testsRun;
   int          testsFailed;

   // Narrow instance
   logic        rst1;
   logic [0:0]  a1;
   logic [0:0]  b1;
   logic [0:0]  c1;
   logic [0:0]  cq1;
   logic [0:0]  rise1;
   logic        clr1;
   logic [15:0] hit1;

   // Wide instance
   logic        rst2;
   logic [3:0]  a2;
   logic [3:0]  b2;
   logic [3:0]  c2;
   logic [3:0]  cq2;
   logic [3:0]  rise2;
   logic        clr2;
   logic [1:0]  hit2;

   and_gate #(.WIDTH(1), .CNT_W(16)) dutNarrow (
      .clk     (clk),
      .rst     (rst1),
      .a       (a1),
      .b       (b1),
      .c       (c1),
      .c_q     (cq1),
      .c_rise  (rise1),
      .cnt_clr (clr1),
      .hit_cnt (hit1)
   );

   and_gate #(.WIDTH(4), .CNT_W(2)) dutWide (
      .clk     (clk),
      .rst     (rst2),
      .a       (a2),
      .b       (b2),
      .c       (c2),
      .c_q     (cq2),
      .c_rise  (rise2),
      .cnt_clr (clr2),
      .hit_cnt (hit2)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop so a broken design can never hang the run.
   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Truth table plus X propagation on the narrow instance, held in reset to
   // show the combinational path ignores it. Vectors start at t = 0, 5, ...
   task automatic test_truth_table();
      logic [0:0] va [6];
      logic [0:0] vb [6];
      logic [0:0] vc [6];
      va[0] = 1'b0; vb[0] = 1'b0; vc[0] = 1'b0;
      va[1] = 1'b0; vb[1] = 1'b1; vc[1] = 1'b0;
      va[2] = 1'b1; vb[2] = 1'b0; vc[2] = 1'b0;
      va[3] = 1'b1; vb[3] = 1'b1; vc[3] = 1'b1;
      va[4] = 1'b0; vb[4] = 1'bx; vc[4] = 1'b0;
      va[5] = 1'b1; vb[5] = 1'bx; vc[5] = 1'bx;
      for (int i = 0; i < 6; i++) begin
         a1 = va[i];
         b1 = vb[i];
         #1;
         testsRun++;
         if (c1 !== vc[i]) begin
            testsFailed++;
            $display("[TB] FAIL truth_table[%0d] a=%b b=%b: c=%b expected %b",
                     i, a1, b1, c1, vc[i]);
         end
         #4;
      end
   endtask

   // Reset held two cycles with a=b=1, then released.
   task automatic test_reset();
      @(negedge clk);
      rst1 = 1'b1; a1 = 1'b1; b1 = 1'b1; clr1 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      testsRun++;
      if ({c1, cq1, rise1, hit1} !== {1'b1, 1'b0, 1'b0, 16'd0}) begin
         testsFailed++;
         $display("[TB] FAIL reset_hold: c=%b c_q=%b c_rise=%b hit=%0d expected 1 0 0 0",
                  c1, cq1, rise1, hit1);
      end
      rst1 = 1'b0;
      @(negedge clk);
      testsRun++;
      if ({cq1, rise1, hit1} !== {1'b1, 1'b1, 16'd1}) begin
         testsFailed++;
         $display("[TB] FAIL reset_release: c_q=%b c_rise=%b hit=%0d expected 1 1 1",
                  cq1, rise1, hit1);
      end
      @(negedge clk);
      testsRun++;
      if ({cq1, rise1} !== {1'b1, 1'b0}) begin
         testsFailed++;
         $display("[TB] FAIL rise_single_pulse: c_q=%b c_rise=%b expected 1 0",
                  cq1, rise1);
      end
   endtask

   // Counting five high cycles, holding, then clearing while c=1.
   task automatic test_count_and_clear();
      clr1 = 1'b1;
      @(negedge clk);
      clr1 = 1'b0;
      testsRun++;
      if (hit1 !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL clear_before_count: hit=%0d expected 0", hit1);
      end
      repeat (5) @(negedge clk);
      a1 = 1'b0;
      testsRun++;
      if (hit1 !== 16'd5) begin
         testsFailed++;
         $display("[TB] FAIL count_five: hit=%0d expected 5", hit1);
      end
      repeat (3) @(negedge clk);
      testsRun++;
      if (hit1 !== 16'd5) begin
         testsFailed++;
         $display("[TB] FAIL count_hold: hit=%0d expected 5", hit1);
      end
      a1 = 1'b1;
      clr1 = 1'b1;
      @(negedge clk);
      clr1 = 1'b0;
      a1 = 1'b0;
      testsRun++;
      if (hit1 !== 16'd0) begin
         testsFailed++;
         $display("[TB] FAIL clear_beats_increment: hit=%0d expected 0", hit1);
      end
   endtask

   // Two-bit counter driven past its maximum; it must stop at 3.
   task automatic test_saturation();
      logic [1:0] expCnt;
      @(negedge clk);
      rst2 = 1'b1; a2 = 4'hF; b2 = 4'hF; clr2 = 1'b0;
      @(negedge clk);
      rst2 = 1'b0;
      testsRun++;
      if (hit2 !== 2'd0) begin
         testsFailed++;
         $display("[TB] FAIL sat_reset: hit=%0d expected 0", hit2);
      end
      for (int n = 1; n <= 6; n++) begin
         @(negedge clk);
         expCnt = (n >= 3) ? 2'd3 : 2'(n);
         testsRun++;
         if (hit2 !== expCnt) begin
            testsFailed++;
            $display("[TB] FAIL saturate[%0d]: hit=%0d expected %0d", n, hit2, expCnt);
         end
      end
      a2 = 4'h0;
      @(negedge clk);
      @(negedge clk);
   endtask

   // Independent lanes on the wide instance.
   task automatic test_wide_lanes();
      a2 = 4'b1100;
      b2 = 4'b1010;
      #1;
      testsRun++;
      if (c2 !== 4'b1000) begin
         testsFailed++;
         $display("[TB] FAIL wide_comb: c=%b expected 1000", c2);
      end
      @(negedge clk);
      testsRun++;
      if ({cq2, rise2} !== {4'b1000, 4'b1000}) begin
         testsFailed++;
         $display("[TB] FAIL wide_reg: c_q=%b c_rise=%b expected 1000 1000", cq2, rise2);
      end
      @(negedge clk);
      testsRun++;
      if ({cq2, rise2} !== {4'b1000, 4'b0000}) begin
         testsFailed++;
         $display("[TB] FAIL wide_steady: c_q=%b c_rise=%b expected 1000 0000", cq2, rise2);
      end
   endtask

   // Reset arriving while the counter sits at 3.
   task automatic test_reset_mid_count();
      @(negedge clk);
      a1 = 1'b0; b1 = 1'b1; clr1 = 1'b1;
      @(negedge clk);
      clr1 = 1'b0;
      a1 = 1'b1;
      repeat (3) @(negedge clk);
      testsRun++;
      if (hit1 !== 16'd3) begin
         testsFailed++;
         $display("[TB] FAIL mid_count_setup: hit=%0d expected 3", hit1);
      end
      rst1 = 1'b1;
      @(negedge clk);
      testsRun++;
      if ({cq1, rise1, hit1} !== {1'b0, 1'b0, 16'd0}) begin
         testsFailed++;
         $display("[TB] FAIL mid_count_reset: c_q=%b c_rise=%b hit=%0d expected 0 0 0",
                  cq1, rise1, hit1);
      end
      a1 = 1'b0;
      #1;
      testsRun++;
      if (c1 !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL comb_in_reset_low: c=%b expected 0", c1);
      end
      a1 = 1'b1;
      #1;
      testsRun++;
      if (c1 !== 1'b1) begin
         testsFailed++;
         $display("[TB] FAIL comb_in_reset_high: c=%b expected 1", c1);
      end
      @(negedge clk);
      rst1 = 1'b0;
      @(negedge clk);
      testsRun++;
      if ({cq1, rise1, hit1} !== {1'b1, 1'b1, 16'd1}) begin
         testsFailed++;
         $display("[TB] FAIL post_reset_rise: c_q=%b c_rise=%b hit=%0d expected 1 1 1",
                  cq1, rise1, hit1);
      end
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      rst1 = 1'b1; a1 = 1'b0; b1 = 1'b0; clr1 = 1'b0;
      rst2 = 1'b1; a2 = 4'h0; b2 = 4'h0; clr2 = 1'b0;
      test_truth_table();
      test_reset();
      test_count_and_clear();
      test_saturation();
      test_wide_lanes();
      test_reset_mid_count();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
